event_input_conditioner: RTL and testbench

EVENT_INPUT_CONDITIONER -- requirements
Module: event_input_conditioner

---
 rtl/event_cond_pkg.sv | 21 ++
 rtl/event_line_detect.sv | 42 ++++
 rtl/event_input_conditioner.sv | 98 +++++++++
 tb/tb_event_input_conditioner.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/event_cond_pkg.sv
// Shared constants for the event input conditioner:
// register indices, line count and the per-line mode encoding.
package event_cond_pkg;

    localparam int NUM_LINES = 32;

    localparam logic [2:0] REG_MODE_LO = 3'd0;
    localparam logic [2:0] REG_MODE_HI = 3'd1;
    localparam logic [2:0] REG_MASK    = 3'd2;
    localparam logic [2:0] REG_SW_TRIG = 3'd3;
    localparam logic [2:0] REG_LEVEL   = 3'd4;
    localparam logic [2:0] REG_CAPTURE = 3'd5;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_RISE  = 2'b01,
        MODE_FALL  = 2'b10,
        MODE_LEVEL = 2'b11
    } line_mode_e;

endpackage

// File: rtl/event_line_detect.sv
// One event line: two-flop synchroniser, history flop and mode-selected
// edge/level detection. The history flop runs regardless of mode.
module event_line_detect
    import event_cond_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       raw,
    input  line_mode_e mode,
    output logic       level,
    output logic       detect
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    always_comb begin
        detect = 1'b0;
        case (mode)
            MODE_RISE:  detect = sync2 & ~prev;
            MODE_FALL:  detect = ~sync2 & prev;
            MODE_LEVEL: detect = sync2;
            default:    detect = 1'b0;
        endcase
    end

    assign level = sync2;

endmodule

// File: rtl/event_input_conditioner.sv
// APB-configured conditioner turning 32 asynchronous event lines into
// registered one-cycle pulses or level requests, plus software triggers.
module event_input_conditioner
    import event_cond_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [31:0]               event_i,
    output logic [31:0]               signal_o
);

    logic        access;
    logic        wr_access;
    logic        rd_access;
    logic [2:0]  idx;
    logic [31:0] mode_lo;
    logic [31:0] mode_hi;
    logic [31:0] mask;
    logic [31:0] capture;
    logic [31:0] level;
    logic [31:0] detect;
    logic [31:0] sw_trig;
    logic [31:0] cap_clr;
    logic [63:0] mode_all;
    logic        unused_addr;

    assign access    = PSEL & PENABLE;
    assign wr_access = access & PWRITE;
    assign rd_access = access & ~PWRITE;
    assign idx       = PADDR[4:2];
    // Only the word index is decoded; the rest of the window aliases.
    assign unused_addr = ^{PADDR[APB_ADDR_WIDTH-1:5], PADDR[1:0]};

    assign PREADY  = 1'b1;
    assign PSLVERR = 1'b0;

    assign sw_trig = (wr_access && idx == REG_SW_TRIG) ? PWDATA : '0;
    assign cap_clr = (wr_access && idx == REG_CAPTURE) ? PWDATA : '0;
    assign mode_all = {mode_hi, mode_lo};

    for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
        event_line_detect u_line (
            .clk    (HCLK),
            .rst    (HRESET),
            .raw    (event_i[gi]),
            .mode   (line_mode_e'(mode_all[2*gi +: 2])),
            .level  (level[gi]),
            .detect (detect[gi])
        );
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            mode_lo  <= '0;
            mode_hi  <= '0;
            mask     <= '0;
            capture  <= '0;
            signal_o <= '0;
        end else begin
            if (wr_access) begin
                case (idx)
                    REG_MODE_LO: mode_lo <= PWDATA;
                    REG_MODE_HI: mode_hi <= PWDATA;
                    REG_MASK:    mask    <= PWDATA;
                    default: ;
                endcase
            end
            // A new detect wins over a same-cycle write-1-to-clear.
            capture  <= (capture & ~cap_clr) | detect;
            signal_o <= (detect & mask) | sw_trig;
        end
    end

    always_comb begin
        PRDATA = '0;
        if (rd_access && !HRESET) begin
            case (idx)
                REG_MODE_LO: PRDATA = mode_lo;
                REG_MODE_HI: PRDATA = mode_hi;
                REG_MASK:    PRDATA = mask;
                REG_LEVEL:   PRDATA = level;
                REG_CAPTURE: PRDATA = capture;
                default:     PRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_event_input_conditioner.sv
// Bench for event_input_conditioner: hand-derived vector table for the
// directed scenarios, then random traffic against a sample-history model.
module tb_event_input_conditioner;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic [11:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic        PWRITE = 1'b0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [31:0] event_i = '0;
    logic [31:0] signal_o;

    event_input_conditioner #(.APB_ADDR_WIDTH(12)) dut (
        .HCLK     (HCLK),
        .HRESET   (HRESET),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PWRITE   (PWRITE),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .event_i  (event_i),
        .signal_o (signal_o)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic        rst;
        logic        acc;
        logic        wr;
        logic [2:0]  idx;
        logic [31:0] wd;
        logic [31:0] ev;
        logic [31:0] exp_sig;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: register contents plus the history of sampled event
    // words, newest first. Entry 1 is what LEVEL shows, entry 2 the one before.
    logic [31:0] m_mode_lo, m_mode_hi, m_mask, m_capture, m_sig;
    logic [31:0] m_samples[$];

    function automatic void add(input logic rst, input logic acc, input logic wr,
                                input logic [2:0] idx, input logic [31:0] wd,
                                input logic [31:0] ev, input logic [31:0] exp_sig,
                                input logic chk_rd, input logic [31:0] exp_rd);
        vec_t v;
        v.rst = rst; v.acc = acc; v.wr = wr; v.idx = idx; v.wd = wd;
        v.ev = ev; v.exp_sig = exp_sig; v.chk_rd = chk_rd; v.exp_rd = exp_rd;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_detect();
        logic [31:0] d;
        logic [63:0] modes;
        int m;
        d = '0;
        modes = {m_mode_hi, m_mode_lo};
        for (int n = 0; n < 32; n++) begin
            logic now_hi;
            logic was_hi;
            m = int'((modes >> (2 * n)) & 64'd3);
            now_hi = m_samples[1][n];
            was_hi = m_samples[2][n];
            if (m == 1)      d[n] = now_hi && !was_hi;
            else if (m == 2) d[n] = !now_hi && was_hi;
            else if (m == 3) d[n] = now_hi;
        end
        return d;
    endfunction

    function automatic logic [31:0] model_read(input logic rst, input logic acc,
                                               input logic wr, input logic [2:0] idx);
        if (rst || !acc || wr) return '0;
        case (idx)
            3'd0:    return m_mode_lo;
            3'd1:    return m_mode_hi;
            3'd2:    return m_mask;
            3'd4:    return m_samples[1];
            3'd5:    return m_capture;
            default: return '0;
        endcase
    endfunction

    task automatic model_step(input logic rst, input logic acc, input logic wr,
                              input logic [2:0] idx, input logic [31:0] wd,
                              input logic [31:0] ev);
        logic [31:0] det, sw, clr;
        if (rst) begin
            m_mode_lo = '0; m_mode_hi = '0; m_mask = '0; m_capture = '0; m_sig = '0;
            m_samples = '{32'h0, 32'h0, 32'h0};
        end else begin
            det = model_detect();
            sw  = (acc && wr && idx == 3'd3) ? wd : '0;
            clr = (acc && wr && idx == 3'd5) ? wd : '0;
            m_sig = (det & m_mask) | sw;
            m_capture = (m_capture & ~clr) | det;
            if (acc && wr) begin
                if (idx == 3'd0) m_mode_lo = wd;
                if (idx == 3'd1) m_mode_hi = wd;
                if (idx == 3'd2) m_mask = wd;
            end
            m_samples.push_front(ev);
            void'(m_samples.pop_back());
        end
    endtask

    // One clock: drive at negedge, check PRDATA before the edge, step the
    // model at the edge and check signal_o just after it.
    task automatic run_cycle(input logic rst, input logic acc, input logic wr,
                             input logic [2:0] idx, input logic [31:0] wd,
                             input logic [31:0] ev,
                             output logic [31:0] sig, output logic [31:0] rd);
        logic [11:0] addr;
        @(negedge HCLK);
        addr = 12'($urandom);
        addr[4:2] = idx;
        addr[1:0] = 2'b00;
        HRESET = rst; PSEL = acc; PENABLE = acc; PWRITE = wr;
        PADDR = addr; PWDATA = wd; event_i = ev;
        #1;
        rd = PRDATA;
        check("prdata_model", PRDATA, model_read(rst, acc, wr, idx));
        @(posedge HCLK);
        model_step(rst, acc, wr, idx, wd, ev);
        #1;
        sig = signal_o;
        check("signal_model", signal_o, m_sig);
    endtask

    initial begin
        logic [31:0] sig, rd, ev;
        m_samples = '{32'h0, 32'h0, 32'h0};
        m_mode_lo = '0; m_mode_hi = '0; m_mask = '0; m_capture = '0; m_sig = '0;

        //  rst acc wr idx wd            ev            exp_sig       chk exp_rd
        add(1, 0, 0, 0, 0,            32'h0,        32'h0,        0,  0);
        add(0, 1, 1, 0, 32'h1,        32'h0,        32'h0,        0,  0);
        add(0, 1, 1, 2, 32'h1,        32'h0,        32'h0,        0,  0);
        add(0, 0, 0, 0, 0,            32'h21,       32'h0,        0,  0);
        add(0, 0, 0, 0, 0,            32'h21,       32'h0,        0,  0);
        add(0, 0, 0, 0, 0,            32'h21,       32'h1,        0,  0);
        add(0, 0, 0, 0, 0,            32'h21,       32'h0,        0,  0);
        add(0, 1, 0, 5, 0,            32'h21,       32'h0,        1,  32'h1);
        add(0, 1, 1, 0, 32'h800,      32'h21,       32'h0,        0,  0);
        add(0, 1, 1, 2, 32'h20,       32'h21,       32'h0,        0,  0);
        add(0, 0, 0, 0, 0,            32'h01,       32'h0,        0,  0);
        add(0, 0, 0, 0, 0,            32'h01,       32'h0,        0,  0);
        add(0, 0, 0, 0, 0,            32'h01,       32'h20,       0,  0);
        add(0, 0, 0, 0, 0,            32'h01,       32'h0,        0,  0);
        for (int i = 0; i < 4; i++)
            add(0, 0, 0, 0, 0,        32'h21,       32'h0,        0,  0);
        add(0, 1, 0, 5, 0,            32'h21,       32'h0,        1,  32'h21);
        add(0, 1, 1, 1, 32'hC,        32'h21,       32'h0,        0,  0);
        add(0, 1, 1, 2, 32'h20000,    32'h21,       32'h0,        0,  0);
        add(0, 0, 0, 0, 0,            32'h20021,    32'h0,        0,  0);
        add(0, 0, 0, 0, 0,            32'h20021,    32'h0,        0,  0);
        for (int i = 0; i < 8; i++)
            add(0, 0, 0, 0, 0,        32'h20021,    32'h20000,    0,  0);
        add(0, 0, 0, 0, 0,            32'h21,       32'h20000,    0,  0);
        add(0, 0, 0, 0, 0,            32'h21,       32'h20000,    0,  0);
        add(0, 0, 0, 0, 0,            32'h21,       32'h0,        0,  0);
        add(0, 0, 0, 0, 0,            32'h20021,    32'h0,        0,  0);
        add(0, 0, 0, 0, 0,            32'h20021,    32'h0,        0,  0);
        add(0, 0, 0, 0, 0,            32'h20021,    32'h20000,    0,  0);
        add(0, 1, 1, 2, 32'h0,        32'h20021,    32'h20000,    0,  0);
        add(0, 0, 0, 0, 0,            32'h20021,    32'h0,        0,  0);
        add(0, 1, 0, 4, 0,            32'h20021,    32'h0,        1,  32'h20021);
        add(0, 1, 1, 3, 32'hA5,       32'h20021,    32'hA5,       0,  0);
        add(0, 0, 0, 0, 0,            32'h20021,    32'h0,        0,  0);
        add(0, 1, 0, 3, 0,            32'h20021,    32'h0,        1,  32'h0);
        add(0, 1, 0, 5, 0,            32'h20021,    32'h0,        1,  32'h20021);
        add(0, 1, 1, 0, 32'h1,        32'h20020,    32'h0,        0,  0);
        add(0, 1, 1, 1, 32'h0,        32'h20020,    32'h0,        0,  0);
        add(0, 1, 1, 5, 32'hFFFFFFFF, 32'h20020,    32'h0,        0,  0);
        add(0, 1, 0, 5, 0,            32'h20020,    32'h0,        1,  32'h0);
        add(0, 0, 0, 0, 0,            32'h20021,    32'h0,        0,  0);
        add(0, 0, 0, 0, 0,            32'h20021,    32'h0,        0,  0);
        add(0, 1, 1, 5, 32'h1,        32'h20021,    32'h0,        0,  0);
        add(0, 1, 0, 5, 0,            32'h20021,    32'h0,        1,  32'h1);
        add(0, 1, 1, 5, 32'h1,        32'h20021,    32'h0,        0,  0);
        add(0, 1, 0, 5, 0,            32'h20021,    32'h0,        1,  32'h0);
        add(0, 1, 0, 0, 0,            32'h20021,    32'h0,        1,  32'h1);
        add(0, 1, 1, 2, 32'h1,        32'h20020,    32'h0,        0,  0);
        add(0, 0, 0, 0, 0,            32'h20020,    32'h0,        0,  0);
        add(0, 0, 0, 0, 0,            32'h20020,    32'h0,        0,  0);
        add(0, 0, 0, 0, 0,            32'h20021,    32'h0,        0,  0);
        add(0, 0, 0, 0, 0,            32'h20021,    32'h0,        0,  0);
        add(1, 1, 0, 0, 0,            32'h20021,    32'h0,        1,  32'h0);
        add(0, 1, 0, 5, 0,            32'h20021,    32'h0,        1,  32'h0);
        add(0, 1, 0, 2, 0,            32'h20021,    32'h0,        1,  32'h0);
        add(0, 1, 0, 0, 0,            32'h20021,    32'h0,        1,  32'h0);
        add(0, 1, 0, 6, 0,            32'h20021,    32'h0,        1,  32'h0);
        add(0, 1, 1, 7, 32'hFFFFFFFF, 32'h20021,    32'h0,        0,  0);
        add(0, 1, 0, 7, 0,            32'h20021,    32'h0,        1,  32'h0);

        foreach (vecs[i]) begin
            run_cycle(vecs[i].rst, vecs[i].acc, vecs[i].wr, vecs[i].idx,
                      vecs[i].wd, vecs[i].ev, sig, rd);
            check($sformatf("tbl_sig[%0d]", i), sig, vecs[i].exp_sig);
            if (vecs[i].chk_rd)
                check($sformatf("tbl_rd[%0d]", i), rd, vecs[i].exp_rd);
        end
        check("pready_pslverr", {30'h0, PSLVERR, PREADY}, 32'h1);

        // Random traffic; sparse event toggles so edges and levels both occur.
        ev = 32'h0;
        for (int i = 0; i < 3000; i++) begin
            logic r_rst, r_acc, r_wr;
            logic [2:0] r_idx;
            r_rst = ($urandom_range(0, 199) == 0);
            r_acc = $urandom_range(0, 1) == 1;
            r_wr  = $urandom_range(0, 1) == 1;
            r_idx = 3'($urandom_range(0, 7));
            ev = ev ^ ($urandom & $urandom & $urandom);
            run_cycle(r_rst, r_acc, r_wr, r_idx, $urandom, ev, sig, rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
